// File: rtl/adbg_jsp_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : adbg_jsp_pkg
// Description : Shared constants, state type and helpers for the JTAG Serial
//               Port debug module.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package adbg_jsp_pkg;

    localparam int DBG_JSP_DATAREG_LEN = 64;
    localparam int DBG_JSP_HDR_LEN     = 8;
    localparam int DBG_JSP_MAX_BYTES   = 7;
    localparam int DBG_JSP_CNT_W       = 4;

    typedef enum logic [1:0] {
        JSP_IDLE = 2'd0,
        JSP_HDR  = 2'd1,
        JSP_DATA = 2'd2,
        JSP_DONE = 2'd3
    } jsp_xfer_state_t;

    function automatic logic [DBG_JSP_CNT_W-1:0] jsp_clamp(
        input logic [DBG_JSP_CNT_W-1:0] value,
        input logic [DBG_JSP_CNT_W-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adbg_jsp_xfer_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : adbg_jsp_xfer_ctrl
// Description : TCK-domain sequencer for one JSP data-register scan: byte-count
//               header exchange followed by up to MAX_BYTES bytes each way.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module adbg_jsp_xfer_ctrl
    import adbg_jsp_pkg::*;
#(
    parameter int DR_LEN    = DBG_JSP_DATAREG_LEN,
    parameter int MAX_BYTES = DBG_JSP_MAX_BYTES
) (
    input  logic                     tck_i,
    input  logic                     rst_i,
    input  logic                     module_select_i,
    input  logic                     capture_dr_i,
    input  logic                     shift_dr_i,
    input  logic                     update_dr_i,
    input  logic                     tdi_i,
    output logic                     tdo_o,
    input  logic [DBG_JSP_CNT_W-1:0] rd_count_i,
    input  logic [7:0]               rd_data_i,
    output logic                     rd_pop_o,
    input  logic [DBG_JSP_CNT_W-1:0] wr_space_i,
    output logic [7:0]               wr_data_o,
    output logic                     wr_push_o,
    output logic                     busy_o
);

    localparam int                       c_bc_w     = $clog2(DR_LEN + 1);
    localparam logic [DBG_JSP_CNT_W-1:0] c_max_cnt  = DBG_JSP_CNT_W'(MAX_BYTES);
    localparam logic [c_bc_w-1:0]        c_hdr_last = c_bc_w'(DBG_JSP_HDR_LEN - 1);
    localparam logic [c_bc_w-1:0]        c_last_bit = c_bc_w'(DR_LEN - 1);
    localparam logic [c_bc_w-1:0]        c_dr_len   = c_bc_w'(DR_LEN);

    jsp_xfer_state_t            r_state,      w_nxt_state;
    logic [c_bc_w-1:0]          r_bit_cnt,    w_nxt_bit_cnt;
    logic [DBG_JSP_CNT_W-1:0]   r_avail,      w_nxt_avail;
    logic [DBG_JSP_CNT_W-1:0]   r_space,      w_nxt_space;
    logic [DBG_JSP_CNT_W-1:0]   r_wcnt_eff,   w_nxt_wcnt_eff;
    logic [DBG_JSP_CNT_W-1:0]   r_rcnt_eff,   w_nxt_rcnt_eff;
    logic [7:1]                 r_in_sr,      w_nxt_in_sr;
    logic [7:0]                 r_out_sr,     w_nxt_out_sr;
    logic [7:0]                 r_wr_data,    w_nxt_wr_data;
    logic                       r_rd_pop,     w_nxt_rd_pop;
    logic                       r_wr_push,    w_nxt_wr_push;

    logic                       w_active;
    logic                       w_shift;
    logic [7:0]                 w_in_byte;
    logic [DBG_JSP_CNT_W-1:0]   w_cap_avail;
    logic [DBG_JSP_CNT_W-1:0]   w_cap_space;
    logic [DBG_JSP_CNT_W-1:0]   w_hdr_wcnt;
    logic [DBG_JSP_CNT_W-1:0]   w_hdr_rcnt;
    logic                       w_slot_end;
    logic [DBG_JSP_CNT_W-1:0]   w_slot;
    logic [DBG_JSP_CNT_W-1:0]   w_slot_nxt;

    assign w_active    = (r_state == JSP_HDR) || (r_state == JSP_DATA);
    assign w_shift     = shift_dr_i && module_select_i && w_active;
    // Byte completed by the bit currently on TDI (header or write slot).
    assign w_in_byte   = {tdi_i, r_in_sr[7:1]};
    assign w_cap_avail = jsp_clamp(rd_count_i, c_max_cnt);
    assign w_cap_space = jsp_clamp(wr_space_i, c_max_cnt);
    assign w_hdr_wcnt  = jsp_clamp(w_in_byte[3:0], r_space);
    assign w_hdr_rcnt  = jsp_clamp(w_in_byte[7:4], r_avail);
    assign w_slot_end  = (r_state == JSP_DATA) && (r_bit_cnt[2:0] == 3'b111);
    assign w_slot      = DBG_JSP_CNT_W'(r_bit_cnt >> 3) - DBG_JSP_CNT_W'(1);
    assign w_slot_nxt  = DBG_JSP_CNT_W'(r_bit_cnt >> 3);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_bit_cnt  = r_bit_cnt;
        w_nxt_avail    = r_avail;
        w_nxt_space    = r_space;
        w_nxt_wcnt_eff = r_wcnt_eff;
        w_nxt_rcnt_eff = r_rcnt_eff;
        w_nxt_in_sr    = r_in_sr;
        w_nxt_out_sr   = r_out_sr;
        w_nxt_wr_data  = r_wr_data;
        w_nxt_rd_pop   = 1'b0;
        w_nxt_wr_push  = 1'b0;

        if (capture_dr_i && module_select_i) begin
            w_nxt_state    = JSP_HDR;
            w_nxt_avail    = w_cap_avail;
            w_nxt_space    = w_cap_space;
            w_nxt_wcnt_eff = '0;
            w_nxt_rcnt_eff = '0;
            w_nxt_in_sr    = '0;
            w_nxt_out_sr   = {w_cap_space, w_cap_avail};
            w_nxt_bit_cnt  = '0;
        end else if (update_dr_i) begin
            w_nxt_state = JSP_IDLE;
        end else if (w_shift) begin
            w_nxt_in_sr  = w_in_byte[7:1];
            w_nxt_out_sr = {1'b0, r_out_sr[7:1]};
            if (r_bit_cnt != c_dr_len) begin
                w_nxt_bit_cnt = r_bit_cnt + c_bc_w'(1);
            end

            if ((r_state == JSP_HDR) && (r_bit_cnt == c_hdr_last)) begin
                w_nxt_state    = JSP_DATA;
                w_nxt_wcnt_eff = w_hdr_wcnt;
                w_nxt_rcnt_eff = w_hdr_rcnt;
                if (w_hdr_rcnt != '0) begin
                    w_nxt_out_sr = rd_data_i;
                    w_nxt_rd_pop = 1'b1;
                end
            end else if (w_slot_end) begin
                // Prefetch the next read byte so it is on TDO for the next slot.
                if (w_slot_nxt < r_rcnt_eff) begin
                    w_nxt_out_sr = rd_data_i;
                    w_nxt_rd_pop = 1'b1;
                end else begin
                    w_nxt_out_sr = '0;
                end
                if (w_slot < r_wcnt_eff) begin
                    w_nxt_wr_data = w_in_byte;
                    w_nxt_wr_push = 1'b1;
                end
                if (r_bit_cnt == c_last_bit) begin
                    w_nxt_state = JSP_DONE;
                end
            end
        end
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_state    <= JSP_IDLE;
            r_bit_cnt  <= '0;
            r_avail    <= '0;
            r_space    <= '0;
            r_wcnt_eff <= '0;
            r_rcnt_eff <= '0;
            r_in_sr    <= '0;
            r_out_sr   <= '0;
            r_wr_data  <= '0;
            r_rd_pop   <= 1'b0;
            r_wr_push  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_bit_cnt  <= w_nxt_bit_cnt;
            r_avail    <= w_nxt_avail;
            r_space    <= w_nxt_space;
            r_wcnt_eff <= w_nxt_wcnt_eff;
            r_rcnt_eff <= w_nxt_rcnt_eff;
            r_in_sr    <= w_nxt_in_sr;
            r_out_sr   <= w_nxt_out_sr;
            r_wr_data  <= w_nxt_wr_data;
            r_rd_pop   <= w_nxt_rd_pop;
            r_wr_push  <= w_nxt_wr_push;
        end
    end

    assign tdo_o     = r_out_sr[0] & w_active;
    assign busy_o    = w_active;
    assign rd_pop_o  = r_rd_pop;
    assign wr_push_o = r_wr_push;
    assign wr_data_o = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_adbg_jsp_xfer_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_adbg_jsp_xfer_ctrl
// Description : Directed self-checking bench for the JSP transfer controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_adbg_jsp_xfer_ctrl;
    import adbg_jsp_pkg::*;

    logic       tck = 1'b0;
    logic       rst = 1'b1;
    logic       module_select = 1'b1;
    logic       capture_dr = 1'b0;
    logic       shift_dr = 1'b0;
    logic       update_dr = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [3:0] rd_count = '0;
    logic [7:0] rd_data;
    logic       rd_pop;
    logic [3:0] wr_space = '0;
    logic [7:0] wr_data;
    logic       wr_push;
    logic       busy;

    logic [7:0] rd_mem [0:15];
    logic [3:0] rd_idx = '0;

    int         n_checks = 0;
    int         n_errors = 0;
    int         pop_cnt;
    int         push_cnt;
    int         pop_at  [0:15];
    int         push_at [0:15];
    logic [7:0] push_log[0:15];
    logic [127:0] dout;

    always #5 tck = ~tck;

    assign rd_data = rd_mem[rd_idx];

    adbg_jsp_xfer_ctrl dut (
        .tck_i          (tck),
        .rst_i          (rst),
        .module_select_i(module_select),
        .capture_dr_i   (capture_dr),
        .shift_dr_i     (shift_dr),
        .update_dr_i    (update_dr),
        .tdi_i          (tdi),
        .tdo_o          (tdo),
        .rd_count_i     (rd_count),
        .rd_data_i      (rd_data),
        .rd_pop_o       (rd_pop),
        .wr_space_i     (wr_space),
        .wr_data_o      (wr_data),
        .wr_push_o      (wr_push),
        .busy_o         (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; strobes are sampled mid-cycle and the FIFO model follows pops.
    task automatic tick(input int idx);
        @(negedge tck);
        if (rd_pop === 1'b1) begin
            if (pop_cnt < 16) pop_at[pop_cnt] = idx;
            pop_cnt++;
            rd_idx = rd_idx + 4'd1;
        end
        if (wr_push === 1'b1) begin
            if (push_cnt < 16) begin
                push_at[push_cnt]  = idx;
                push_log[push_cnt] = wr_data;
            end
            push_cnt++;
        end
    endtask

    task automatic clear_log();
        pop_cnt  = 0;
        push_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            pop_at[i]   = -1;
            push_at[i]  = -1;
            push_log[i] = '0;
        end
    endtask

    task automatic load_fifo(input logic [55:0] bytes, input int n);
        for (int i = 0; i < n; i++) rd_mem[rd_idx + 4'(i)] = bytes[i*8 +: 8];
        rd_count = 4'(n);
    endtask

    task automatic capture();
        capture_dr = 1'b1;
        tick(-1);
        capture_dr = 1'b0;
    endtask

    task automatic update();
        update_dr = 1'b1;
        tick(-2);
        update_dr = 1'b0;
    endtask

    task automatic shift_bits(input logic [127:0] din, input int n, output logic [127:0] dq);
        dq = '0;
        for (int i = 0; i < n; i++) begin
            shift_dr = 1'b1;
            tdi      = din[i];
            dq[i]    = tdo;
            tick(i);
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rd_mem[i] = '0;
        clear_log();

        // Reset values
        repeat (3) tick(-3);
        check_eq("rst_tdo", 64'(tdo), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_pop", 64'(rd_pop), 64'd0);
        check_eq("rst_push", 64'(wr_push), 64'd0);
        check_eq("rst_wdata", 64'(wr_data), 64'd0);
        rst = 1'b0;
        tick(-3);

        // Header only: avail 3, space clamped 10 -> 7
        clear_log();
        load_fifo(56'h0, 3);
        wr_space = 4'd10;
        capture();
        check_eq("hdr_busy", 64'(busy), 64'd1);
        shift_bits(128'h0, 8, dout);
        check_eq("hdr_tdo", 64'(dout[7:0]), 64'h73);
        check_eq("hdr_pops", 64'(pop_cnt), 64'd0);
        check_eq("hdr_pushes", 64'(push_cnt), 64'd0);
        update();
        check_eq("hdr_idle_busy", 64'(busy), 64'd0);

        // Write only: wcnt 2, bytes A5, 3C
        clear_log();
        rd_count = 4'd0;
        wr_space = 4'd7;
        capture();
        shift_bits(128'h3C_A5_02, 64, dout);
        check_eq("wr_tdo_hdr", 64'(dout[7:0]), 64'h70);
        check_eq("wr_pushes", 64'(push_cnt), 64'd2);
        check_eq("wr_data0", 64'(push_log[0]), 64'hA5);
        check_eq("wr_data1", 64'(push_log[1]), 64'h3C);
        check_eq("wr_at0", 64'(push_at[0]), 64'd15);
        check_eq("wr_at1", 64'(push_at[1]), 64'd23);
        check_eq("wr_pops", 64'(pop_cnt), 64'd0);
        check_eq("wr_done_busy", 64'(busy), 64'd0);
        check_eq("wr_hold", 64'(wr_data), 64'h3C);
        update();

        // Read clamp: 2 bytes available, host asks 5
        clear_log();
        load_fifo(56'h22_11, 2);
        wr_space = 4'd0;
        capture();
        shift_bits(128'h50, 64, dout);
        check_eq("rd_tdo_hdr", 64'(dout[7:0]), 64'h02);
        check_eq("rd_pops", 64'(pop_cnt), 64'd2);
        check_eq("rd_pop_at0", 64'(pop_at[0]), 64'd7);
        check_eq("rd_pop_at1", 64'(pop_at[1]), 64'd15);
        check_eq("rd_slot0", 64'(dout[15:8]), 64'h11);
        check_eq("rd_slot1", 64'(dout[23:16]), 64'h22);
        check_eq("rd_slots2_6", 64'(dout[63:24]), 64'h0);
        check_eq("rd_pushes", 64'(push_cnt), 64'd0);
        update();

        // Full duplex 7x7, then 6 extra shifts past the end
        clear_log();
        load_fifo(56'hF0_6D_9A_07_3E_52_C1, 7);
        wr_space = 4'd7;
        capture();
        shift_bits(128'hCD_AB_89_67_45_23_01_77, 70, dout);
        check_eq("fd_tdo_hdr", 64'(dout[7:0]), 64'h77);
        check_eq("fd_tdo_data", 64'(dout[63:8]), 64'hF0_6D_9A_07_3E_52_C1);
        check_eq("fd_tdo_after", 64'(dout[69:64]), 64'h0);
        check_eq("fd_pops", 64'(pop_cnt), 64'd7);
        check_eq("fd_pushes", 64'(push_cnt), 64'd7);
        check_eq("fd_wbytes", {8'h0, push_log[6], push_log[5], push_log[4], push_log[3],
                               push_log[2], push_log[1], push_log[0]}, 64'hCD_AB_89_67_45_23_01);
        check_eq("fd_last_push_at", 64'(push_at[6]), 64'd63);
        check_eq("fd_last_pop_at", 64'(pop_at[6]), 64'd55);
        check_eq("fd_done_busy", 64'(busy), 64'd0);
        update();

        // Abort after bit 20 with wcnt 3
        clear_log();
        rd_count = 4'd0;
        wr_space = 4'd7;
        capture();
        shift_bits(128'h77_69_5A_03, 21, dout);
        update();
        check_eq("ab_busy", 64'(busy), 64'd0);
        shift_bits(128'hFFFF, 10, dout);
        check_eq("ab_pushes", 64'(push_cnt), 64'd1);
        check_eq("ab_data0", 64'(push_log[0]), 64'h5A);
        check_eq("ab_idle_tdo", 64'(dout[9:0]), 64'h0);

        // Reset in the cycle that would shift bit 31
        clear_log();
        load_fifo(56'h0C_0B_0A, 3);
        wr_space = 4'd7;
        capture();
        shift_bits(128'h00_E3_E2_E1_33, 31, dout);
        check_eq("rs_pre_pushes", 64'(push_cnt), 64'd2);
        check_eq("rs_pre_pops", 64'(pop_cnt), 64'd3);
        rst      = 1'b1;
        shift_dr = 1'b1;
        tdi      = 1'b1;
        tick(31);
        shift_dr = 1'b0;
        tdi      = 1'b0;
        check_eq("rs_pushes", 64'(push_cnt), 64'd2);
        check_eq("rs_pops", 64'(pop_cnt), 64'd3);
        check_eq("rs_busy", 64'(busy), 64'd0);
        check_eq("rs_tdo", 64'(tdo), 64'd0);
        check_eq("rs_wdata", 64'(wr_data), 64'd0);
        rst = 1'b0;
        tick(-3);

        // Capture and shift while the module is not selected
        module_select = 1'b0;
        rd_count = 4'd5;
        capture();
        check_eq("ns_busy", 64'(busy), 64'd0);
        shift_bits(128'hFF, 8, dout);
        check_eq("ns_tdo", 64'(dout[7:0]), 64'h0);
        check_eq("ns_strobes", 64'(push_cnt + pop_cnt), 64'd5);
        module_select = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
